rd_fifo_status_ctrl: RTL and testbench
======================================

// Module: rd_fifo_status_ctrl
// PURPOSE
//  Read-side counterpart of the VDMA write-channel FIFO status controller.
//  - Watches free space in the read-channel stream FIFO, which AXI read data fills and the video output drains.
//  - Requests AXI read bursts from the read engine until one frame's beat count has been fetched.
//  - Sits between the read-FIFO count logic and the AXI read-address/burst engine.
//  - Last burst of each frame is shortened to the remaining length (tail).
// PARAMETERS
//  DEPTH      512       FIFO depth in beats (count range 0..DEPTH)
//  BURST_LEN  100       nominal burst length in beats, 1..2^LSIZE-1
//  MARGIN     16        extra free beats required beyond the request length
//  LSIZE      9         width of req_len
//  FSIZE      24        width of frame_len / remaining counter
//  TIMEOUT    24'hFFF000 cycles allowed in REQ or WAIT_DONE before error
// PORTS
//  clock       in  1      single clock; all logic is rising-edge
//  rst         in  1      asynchronous, active-high reset
//  enable      in  1      0: no new request starts (an in-flight burst completes)
//  frame_start in  1      1-cycle pulse: reload remaining <= frame_len
//  frame_len   in  FSIZE  beats per frame; sampled on frame_start
//  count       in  10     current FIFO fill in beats
//  resp        in  1      engine accepted the request (1-cycle pulse)
//  done        in  1      engine finished the last beat of the burst (pulse)
//  burst_req   out 1      request pending; hold until resp
//  req_len     out LSIZE  length of the pending/current burst
//  burst_done  out 1      1-cycle pulse after each completed burst
//  frame_done  out 1      1-cycle pulse when remaining reaches 0
//  rst_chain   out 1      1-cycle pulse on timeout; resets engine and FIFO
//  busy        out 1      high in every state except IDLE and FLUSH
// BEHAVIOUR
//  Reset values
//  - All outputs are 0; state = IDLE; remaining = 0; tcnt = 0; pend_start = 0.
//  Derived values
//  - space = DEPTH - count, computed at 11 bits; count > DEPTH is treated as space = 0.
//  - nxt_len = (remaining < BURST_LEN) ? remaining[LSIZE-1:0] : BURST_LEN.
//  - go_r is a register: enable & (remaining != 0) & (space >= nxt_len + MARGIN) & !pend_start.
//  - Because go_r is registered, a request starts no earlier than 2 cycles after the condition holds.
//  State machine
//  - IDLE: if pend_start, reload remaining and clear pend_start.
//    Else if go_r, capture req_len <= nxt_len and go to REQ.
//  - REQ: burst_req = 1. Go to WAIT_DONE on resp. Go to TIME_ERR when tcnt == TIMEOUT.
//  - WAIT_DONE: go to FSH on done. Go to TIME_ERR on timeout.
//    resp and done in the same cycle in REQ: take REQ->WAIT_DONE only; done is lost.
//    The engine guarantees done comes at least 1 cycle after resp.
//  - FSH: remaining <= remaining - req_len. Pulse burst_done.
//    Pulse frame_done in the same cycle if the result is 0. Then go to IDLE.
//  - TIME_ERR: pulse rst_chain for 1 cycle; remaining <= 0; go to FLUSH.
//  - FLUSH: wait for frame_start, then go to IDLE with remaining reloaded.
//  Registered outputs
//  - burst_req is registered from (nstate == REQ), so it is high exactly while in REQ.
//  - req_len holds its value until the next IDLE->REQ transition.
//  frame_start timing
//  - In IDLE or FLUSH: applied immediately, and the reload wins over any go_r in that cycle.
//  - In REQ, WAIT_DONE or FSH: latched into pend_start and applied on return to IDLE.
//  - The decrement in FSH is still applied first; frame_done is suppressed while pend_start = 1.
//  Timeout counter
//  - tcnt counts only in REQ and WAIT_DONE and clears in all other states.
//  - It saturates and never wraps.
//  Edge cases
//  - remaining is never decremented below 0: req_len <= remaining by construction.
//  - frame_len = 0: no request is issued and no frame_done is pulsed.
//  - rst asserted mid-burst: returns to IDLE immediately and drops burst_req in the same cycle (async).
//  - enable low in REQ: the request is still held until resp.
// STRUCTURE
//  Shared package vdma_pkg:
//  - State localparams as a typedef'd enum: IDLE, REQ, WAIT_DONE, FSH, TIME_ERR, FLUSH.
//  - DEPTH and the COUNT_W = 10 constant.
//  Sub-module rd_space_calc (combinational plus go_r register):
//  - Holds the space and nxt_len arithmetic so the FIFO-space check can be tested on its own.
//  - FSM, remaining counter and timeout counter stay in the top module.
// TESTING
//  DEPTH=512, BURST_LEN=100, MARGIN=16.
//  1. frame_len=250, count=0, resp 2 cycles after each req, done 10 cycles after resp
//     -> req_len 100,100,50; 3 burst_done pulses; frame_done with the 3rd burst_done.
//  2. count=400 (space 112 < 116) -> no burst_req.
//     Then count=396 -> burst_req rises 2 cycles later with req_len=100.
//  3. frame_start pulsed while in WAIT_DONE, frame_len=300
//     -> current burst completes; remaining=300 after IDLE; no frame_done.
//  4. resp never asserted, TIMEOUT set to 32 in sim
//     -> rst_chain pulse 33 cycles after REQ entry; FLUSH until frame_start.
//  5. rst pulsed high mid-REQ -> burst_req = 0 in the same cycle; all outputs 0; state IDLE.
//  6. enable = 0 with space available and remaining > 0 -> no request.
//     Raise enable -> burst_req rises within 2 cycles.

Source files
------------

// File: rtl/vdma_pkg.sv
// Shared VDMA definitions: FIFO geometry and the status-controller state encoding.
package vdma_pkg;

    localparam int unsigned DEPTH   = 512;
    localparam int unsigned COUNT_W = 10;
    localparam int unsigned SPACE_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DONE,
        FSH,
        TIME_ERR,
        FLUSH
    } state_t;

endpackage

// File: rtl/rd_space_calc.sv
// FIFO free-space check for the read channel.
// Ports:
//   clock, rst   rising-edge clock, async active-high reset
//   enable       allows a new request to be armed
//   arm          controller is idle and not reloading this cycle
//   count        current FIFO fill in beats
//   remaining    beats still to fetch for the current frame
//   pend_start   a frame reload is pending
//   nxt_len_c    length the next burst would have (combinational)
//   go_r         registered "start a burst" qualifier
module rd_space_calc
    import vdma_pkg::*;
#(
    parameter int unsigned DEPTH     = vdma_pkg::DEPTH,
    parameter int unsigned BURST_LEN = 100,
    parameter int unsigned MARGIN    = 16,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned FSIZE     = 24
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    input  logic               arm,
    input  logic [COUNT_W-1:0] count,
    input  logic [FSIZE-1:0]   remaining,
    input  logic               pend_start,
    output logic [LSIZE-1:0]   nxt_len_c,
    output logic               go_r
);

    localparam int unsigned CMP_W = ((LSIZE > SPACE_W) ? LSIZE : SPACE_W) + 2;

    logic [SPACE_W-1:0] space_c;
    logic [CMP_W-1:0]   need_c;
    logic               fits_c;

    // Free space; an over-range count reads as a full FIFO.
    always_comb begin
        space_c = '0;
        if (SPACE_W'(count) <= SPACE_W'(DEPTH)) begin
            space_c = SPACE_W'(DEPTH) - SPACE_W'(count);
        end
    end

    // Next burst length: nominal, or the frame tail when shorter.
    always_comb begin
        nxt_len_c = LSIZE'(BURST_LEN);
        if (remaining < FSIZE'(BURST_LEN)) begin
            nxt_len_c = remaining[LSIZE-1:0];
        end
    end

    assign need_c = CMP_W'(nxt_len_c) + CMP_W'(MARGIN);
    assign fits_c = CMP_W'(space_c) >= need_c;

    // Qualified only while idle so a stale go_r never follows a decrement or reload.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            go_r <= 1'b0;
        end else begin
            go_r <= arm & enable & (remaining != '0) & fits_c & ~pend_start;
        end
    end

endmodule

// File: rtl/rd_fifo_status_ctrl.sv
// Read-channel FIFO status controller: issues AXI read bursts to the read
// engine while the stream FIFO has room, until a frame's beats are fetched.
// Ports:
//   clock, rst     rising-edge clock, async active-high reset
//   enable         gates new requests (an in-flight burst still completes)
//   frame_start    pulse: reload the remaining counter from frame_len
//   frame_len      beats per frame
//   count          FIFO fill in beats
//   resp, done     engine accepted request / finished last beat
//   burst_req      request pending, held until resp
//   req_len        length of the pending/current burst
//   burst_done     pulse per completed burst
//   frame_done     pulse when the frame is fully fetched
//   rst_chain      pulse on timeout, resets engine and FIFO
//   busy           high outside IDLE and FLUSH
module rd_fifo_status_ctrl
    import vdma_pkg::*;
#(
    parameter int unsigned DEPTH     = vdma_pkg::DEPTH,
    parameter int unsigned BURST_LEN = 100,
    parameter int unsigned MARGIN    = 16,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned FSIZE     = 24,
    parameter int unsigned TIMEOUT   = 24'hFFF000
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame_start,
    input  logic [FSIZE-1:0]   frame_len,
    input  logic [COUNT_W-1:0] count,
    input  logic               resp,
    input  logic               done,
    output logic               burst_req,
    output logic [LSIZE-1:0]   req_len,
    output logic               burst_done,
    output logic               frame_done,
    output logic               rst_chain,
    output logic               busy
);

    state_t             state, nstate;
    logic [FSIZE-1:0]   remaining, remaining_nxt;
    logic               pend_start, pend_start_nxt;
    logic [FSIZE-1:0]   pend_len, pend_len_nxt;
    logic [LSIZE-1:0]   req_len_nxt;
    logic [FSIZE-1:0]   tcnt, tcnt_nxt;
    logic [LSIZE-1:0]   nxt_len_c;
    logic               go_r;
    logic               arm_c;
    logic               tmo_c;
    logic               in_burst_c;
    logic               frame_fin_c;

    assign arm_c      = (state == IDLE) & ~frame_start & ~pend_start;
    assign tmo_c      = (tcnt == FSIZE'(TIMEOUT));
    assign in_burst_c = (state == REQ) | (state == WAIT_DONE);

    rd_space_calc #(
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .MARGIN    (MARGIN),
        .LSIZE     (LSIZE),
        .FSIZE     (FSIZE)
    ) u_space (
        .clock      (clock),
        .rst        (rst),
        .enable     (enable),
        .arm        (arm_c),
        .count      (count),
        .remaining  (remaining),
        .pend_start (pend_start),
        .nxt_len_c  (nxt_len_c),
        .go_r       (go_r)
    );

    // Next-state, counters and frame bookkeeping.
    always_comb begin
        nstate         = state;
        remaining_nxt  = remaining;
        pend_start_nxt = pend_start;
        pend_len_nxt   = pend_len;
        req_len_nxt    = req_len;
        tcnt_nxt       = '0;
        frame_fin_c    = 1'b0;

        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    remaining_nxt  = frame_len;
                    pend_start_nxt = 1'b0;
                end else if (pend_start) begin
                    remaining_nxt  = pend_len;
                    pend_start_nxt = 1'b0;
                end else if (go_r) begin
                    req_len_nxt = nxt_len_c;
                    nstate      = REQ;
                end
            end
            REQ: begin
                if (tmo_c) begin
                    nstate = TIME_ERR;
                end else if (resp) begin
                    nstate = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tmo_c) begin
                    nstate = TIME_ERR;
                end else if (done) begin
                    nstate = FSH;
                end
            end
            FSH: begin
                remaining_nxt = remaining - FSIZE'(req_len);
                nstate        = IDLE;
            end
            TIME_ERR: begin
                remaining_nxt  = '0;
                pend_start_nxt = 1'b0;
                nstate         = FLUSH;
            end
            FLUSH: begin
                if (frame_start) begin
                    remaining_nxt = frame_len;
                    nstate        = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase

        // A new frame arriving mid-burst is parked until the controller idles.
        if (frame_start && ((state == REQ) || (state == WAIT_DONE) || (state == FSH))) begin
            pend_start_nxt = 1'b1;
            pend_len_nxt   = frame_len;
        end

        // Saturating timeout counter, live only while a burst is outstanding.
        if (in_burst_c) begin
            tcnt_nxt = (tcnt == '1) ? tcnt : tcnt + FSIZE'(1);
        end

        // Pulses are registered from nstate so they line up with the FSH/TIME_ERR states.
        frame_fin_c = (nstate == FSH) & (remaining == FSIZE'(req_len)) & ~pend_start_nxt;
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            pend_start <= 1'b0;
            pend_len   <= '0;
            tcnt       <= '0;
            req_len    <= '0;
            burst_req  <= 1'b0;
            burst_done <= 1'b0;
            frame_done <= 1'b0;
            rst_chain  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nstate;
            remaining  <= remaining_nxt;
            pend_start <= pend_start_nxt;
            pend_len   <= pend_len_nxt;
            tcnt       <= tcnt_nxt;
            req_len    <= req_len_nxt;
            burst_req  <= (nstate == REQ);
            burst_done <= (nstate == FSH);
            frame_done <= frame_fin_c;
            rst_chain  <= (nstate == TIME_ERR);
            busy       <= ~((nstate == IDLE) | (nstate == FLUSH));
        end
    end

endmodule

// File: tb/tb_rd_fifo_status_ctrl.sv
// Scoreboard bench for rd_fifo_status_ctrl: frames are split into expected
// bursts by a simple chunking model; a monitor compares DUT events in order.
module tb_rd_fifo_status_ctrl;
    import vdma_pkg::*;

    localparam int unsigned LSIZE = 9;
    localparam int unsigned FSIZE = 24;
    localparam int unsigned BURST = 100;
    localparam int unsigned MARG  = 16;
    localparam int unsigned TMO   = 32;

    logic               clock = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               frame_start = 1'b0;
    logic [FSIZE-1:0]   frame_len = '0;
    logic [COUNT_W-1:0] count = '0;
    logic               resp = 1'b0;
    logic               done = 1'b0;
    logic               burst_req;
    logic [LSIZE-1:0]   req_len;
    logic               burst_done;
    logic               frame_done;
    logic               rst_chain;
    logic               busy;

    rd_fifo_status_ctrl #(
        .DEPTH(512), .BURST_LEN(BURST), .MARGIN(MARG),
        .LSIZE(LSIZE), .FSIZE(FSIZE), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable), .frame_start(frame_start),
        .frame_len(frame_len), .count(count), .resp(resp), .done(done),
        .burst_req(burst_req), .req_len(req_len), .burst_done(burst_done),
        .frame_done(frame_done), .rst_chain(rst_chain), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef enum int {EV_REQ, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int unsigned val;
        bit          fd;
    } ev_t;

    ev_t         exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    bit          engine_on = 1'b1;
    int          resp_dly = 2;
    int          done_dly = 10;
    logic        prev_req = 1'b0;
    int unsigned req_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input ev_kind_t k, input int unsigned v, input bit fd);
        ev_t e;
        e.kind = k; e.val = v; e.fd = fd;
        exp_q.push_back(e);
    endtask

    // Reference model: a frame is fetched in nominal-size chunks plus a tail.
    task automatic push_frame(input int unsigned len);
        int unsigned r = len;
        int unsigned l;
        while (r > 0) begin
            l = (r < BURST) ? r : BURST;
            r = r - l;
            push(EV_REQ, l, 1'b0);
            push(EV_DONE, 0, r == 0);
        end
    endtask

    task automatic pop_cmp(input ev_kind_t k, input int unsigned v, input bit fd, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind=%0d val=%0d fd=%0d, none expected", name, k, v, fd);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.fd != fd) begin
                errors++;
                $display("FAIL %s: got kind=%0d val=%0d fd=%0d expected kind=%0d val=%0d fd=%0d",
                         name, k, v, fd, e.kind, e.val, e.fd);
            end
        end
    endtask

    // Monitor: every DUT event is matched against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (burst_req && !prev_req) begin
                req_cyc = cyc;
                pop_cmp(EV_REQ, int'(req_len), 1'b0, "burst_req/req_len");
            end
            if (burst_done) pop_cmp(EV_DONE, 0, frame_done, "burst_done/frame_done");
            if (frame_done) check("frame_done with burst_done", longint'(burst_done), 1);
            if (rst_chain) pop_cmp(EV_ERR, cyc - req_cyc, 1'b0, "rst_chain timing");
            prev_req = burst_req;
        end
    end

    // Read engine model: resp after resp_dly cycles, done done_dly cycles later.
    initial begin
        forever begin
            @(negedge clock);
            if (engine_on && burst_req) begin
                repeat (resp_dly - 1) @(negedge clock);
                resp = 1'b1;
                @(negedge clock);
                resp = 1'b0;
                repeat (done_dly - 1) @(negedge clock);
                done = 1'b1;
                @(negedge clock);
                done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_frame(input int unsigned len);
        @(negedge clock);
        frame_len   = FSIZE'(len);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check({name, " all expected events seen"}, exp_q.size(), 0);
        exp_q.delete();
        tick(6);
    endtask

    task automatic req_latency(output int lat);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            #1;
            if (burst_req && lat == 0) lat = k;
        end
    endtask

    initial begin
        int lat;
        int got;
        int unsigned flen;

        // Reset state
        tick(3);
        check("reset burst_req", burst_req, 0);
        check("reset req_len", req_len, 0);
        check("reset burst_done", burst_done, 0);
        check("reset frame_done", frame_done, 0);
        check("reset rst_chain", rst_chain, 0);
        check("reset busy", busy, 0);
        @(negedge clock);
        rst    = 1'b0;
        enable = 1'b1;
        tick(2);

        // 250-beat frame: 100, 100, 50 tail
        resp_dly = 2; done_dly = 10;
        push_frame(250);
        start_frame(250);
        wait_drain(400, "frame 250");
        check("idle after frame 250", busy, 0);

        // Random frame lengths and engine latencies
        for (int i = 0; i < 6; i++) begin
            flen     = $urandom_range(1, 450);
            resp_dly = $urandom_range(1, 4);
            done_dly = $urandom_range(1, 6);
            push_frame(flen);
            start_frame(flen);
            wait_drain(1000, "random frame");
        end
        resp_dly = 2; done_dly = 10;

        // Zero-length frame: nothing issued
        start_frame(0);
        tick(20);
        check("frame_len 0 idle", busy, 0);

        // Space boundary: 112 free < 116 needed, then 116 free
        count = COUNT_W'(400);
        start_frame(100);
        tick(20);
        check("no req with space 112", burst_req, 0);
        push_frame(100);
        @(negedge clock);
        count = COUNT_W'(396);
        req_latency(lat);
        check("req latency after space ok", lat, 2);
        wait_drain(300, "space boundary");
        count = '0;

        // Frame restart while a burst is outstanding
        push(EV_REQ, 100, 1'b0);
        push(EV_DONE, 0, 1'b0);
        push_frame(300);
        start_frame(100);
        got = 0;
        for (int n = 0; n < 50 && got == 0; n++) begin
            @(posedge clock);
            if (resp) got = 1;
        end
        check("resp seen before restart", got, 1);
        @(negedge clock);
        frame_len   = FSIZE'(300);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        wait_drain(600, "restart in WAIT_DONE");

        // Timeout: engine silent
        engine_on = 1'b0;
        push(EV_REQ, 100, 1'b0);
        push(EV_ERR, TMO + 1, 1'b0);
        start_frame(100);
        wait_drain(200, "timeout");
        check("flush not busy", busy, 0);
        tick(20);
        check("flush holds no req", burst_req, 0);
        engine_on = 1'b1;
        push_frame(50);
        start_frame(50);
        wait_drain(300, "after flush");

        // Async reset mid-request
        engine_on = 1'b0;
        push(EV_REQ, 100, 1'b0);
        start_frame(100);
        got = 0;
        for (int n = 0; n < 10 && got == 0; n++) begin
            @(negedge clock);
            if (burst_req) got = 1;
        end
        check("req before reset", got, 1);
        tick(3);
        @(negedge clock);
        rst = 1'b1;
        #1;
        check("async rst burst_req", burst_req, 0);
        check("async rst busy", busy, 0);
        check("async rst req_len", req_len, 0);
        check("async rst pulses", {burst_done, frame_done, rst_chain}, 0);
        @(negedge clock);
        rst = 1'b0;
        tick(20);
        check("no activity after reset", exp_q.size(), 0);
        engine_on = 1'b1;

        // Enable gating
        enable = 1'b0;
        start_frame(100);
        tick(20);
        check("no req while disabled", burst_req, 0);
        push_frame(100);
        @(negedge clock);
        enable = 1'b1;
        req_latency(lat);
        check("req latency after enable", lat, 2);
        wait_drain(300, "enable");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
